// File: rtl/scsi_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scsi_io_pkg
//  Description : Shared constants for the SCSI sector mover: sector geometry,
//                backend command direction encoding and FSM state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package scsi_io_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = $clog2(SECTOR_BYTES);

    localparam logic BLK_DIR_READ  = 1'b0;
    localparam logic BLK_DIR_WRITE = 1'b1;

    // State codes are plain constants so older code that compares raw
    // 3-bit values keeps working.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_RD_XFER = 3'd2;
    localparam logic [2:0] ST_WR_XFER = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/scsi_sector_mover.sv
`default_nettype none
// ============================================================================
//  Module      : scsi_sector_mover
//  Description : Services one-sector read/write requests from the SCSI
//                target io interface, moving SECTOR_BYTES bytes between the
//                target sector buffer (sd_buff_*) and a byte-stream backend.
//                Requests at or beyond the mounted image size are answered
//                locally (zero fill on read, discard on write) and flagged
//                on range_err.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset         clock, asynchronous active-high reset
//    img_mounted/blocks image size strobe and value (sectors)
//    io_lba/rd/wr/ack   request interface from the target
//    sd_buff_*          target sector buffer (din has 1 clk read latency)
//    blk_req/write/lba  backend command, held until blk_gnt
//    rd_data/valid/ready   backend -> buffer byte stream
//    wr_data/valid/ready   buffer -> backend byte stream
//    range_err          sticky out-of-range flag
// ============================================================================
module scsi_sector_mover #(
    parameter int SECTOR_BYTES = 512,
    parameter int LBA_W        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            img_mounted,
    input  logic [LBA_W-1:0]                img_blocks,
    input  logic [LBA_W-1:0]                io_lba,
    input  logic                            io_rd,
    input  logic                            io_wr,
    output logic                            io_ack,
    output logic [$clog2(SECTOR_BYTES)-1:0] sd_buff_addr,
    output logic [7:0]                      sd_buff_dout,
    output logic                            sd_buff_wr,
    input  logic [7:0]                      sd_buff_din,
    output logic                            blk_req,
    output logic                            blk_write,
    output logic [LBA_W-1:0]                blk_lba,
    input  logic                            blk_gnt,
    input  logic [7:0]                      rd_data,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    output logic [7:0]                      wr_data,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic                            range_err
);
    import scsi_io_pkg::BLK_DIR_READ;
    import scsi_io_pkg::BLK_DIR_WRITE;
    import scsi_io_pkg::ST_IDLE;
    import scsi_io_pkg::ST_CMD;
    import scsi_io_pkg::ST_RD_XFER;
    import scsi_io_pkg::ST_WR_XFER;
    import scsi_io_pkg::ST_ERR;
    import scsi_io_pkg::ST_DONE;

    localparam int            AW     = $clog2(SECTOR_BYTES);
    localparam logic [AW-1:0] C_LAST = AW'(SECTOR_BYTES - 1);

    logic [2:0]       r_state;
    logic [LBA_W-1:0] r_lba;
    logic [LBA_W-1:0] r_img_size;
    logic             r_dir;
    logic [AW-1:0]    r_cnt;          // beats moved (read/write) or zeros written (err)
    logic             r_gap;          // one IDLE cycle after DONE where requests are ignored
    logic             r_din_ok;       // sd_buff_din holds the byte at sd_buff_addr
    logic             r_fetch_done;   // last buffer byte already fetched

    logic w_req;
    logic w_wr_accept;
    logic w_out_free;

    assign w_req       = (io_rd | io_wr) & ~io_ack & ~r_gap;
    assign w_wr_accept = wr_valid & wr_ready;
    assign w_out_free  = ~wr_valid | wr_ready;

    // Command and read-ready are pure decodes of the state, so they vanish
    // together with the state on an asynchronous reset.
    assign rd_ready  = (r_state == ST_RD_XFER);
    assign blk_req   = (r_state == ST_CMD);
    assign blk_write = blk_req & r_dir;
    assign blk_lba   = blk_req ? r_lba : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lba        <= '0;
            r_img_size   <= '0;
            r_dir        <= BLK_DIR_READ;
            r_cnt        <= '0;
            r_gap        <= 1'b0;
            r_din_ok     <= 1'b0;
            r_fetch_done <= 1'b0;
            io_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            wr_data      <= '0;
            wr_valid     <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            sd_buff_wr <= 1'b0;

            // A running transfer was range-checked at accept time, so a new
            // size only affects the next request.
            if (img_mounted) begin
                r_img_size <= img_blocks;
            end

            case (r_state)
                ST_IDLE: begin
                    r_gap <= 1'b0;
                    if (w_req) begin
                        r_dir  <= io_rd ? BLK_DIR_READ : BLK_DIR_WRITE;
                        r_lba  <= io_lba;
                        r_cnt  <= '0;
                        io_ack <= 1'b1;
                        if (io_lba >= r_img_size) begin
                            range_err <= 1'b1;
                            r_state   <= ST_ERR;
                        end else begin
                            range_err <= 1'b0;
                            r_state   <= ST_CMD;
                        end
                    end
                end

                ST_CMD: begin
                    if (blk_gnt) begin
                        if (r_dir == BLK_DIR_WRITE) begin
                            r_state      <= ST_WR_XFER;
                            sd_buff_addr <= '0;
                            r_din_ok     <= 1'b0;
                            r_fetch_done <= 1'b0;
                        end else begin
                            r_state <= ST_RD_XFER;
                        end
                    end
                end

                ST_RD_XFER: begin
                    if (rd_valid) begin
                        sd_buff_wr   <= 1'b1;
                        sd_buff_dout <= rd_data;
                        sd_buff_addr <= r_cnt;
                        r_cnt        <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_WR_XFER: begin
                    // An address held for one cycle yields valid din the next.
                    r_din_ok <= 1'b1;
                    if (w_wr_accept) begin
                        wr_valid <= 1'b0;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                    // Load the next byte only when the output slot is free,
                    // then immediately start fetching the one after it.
                    if (w_out_free && r_din_ok && !r_fetch_done) begin
                        wr_data  <= sd_buff_din;
                        wr_valid <= 1'b1;
                        if (sd_buff_addr == C_LAST) begin
                            r_fetch_done <= 1'b1;
                        end else begin
                            sd_buff_addr <= sd_buff_addr + 1'b1;
                            r_din_ok     <= 1'b0;
                        end
                    end
                end

                ST_ERR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_dir == BLK_DIR_READ) begin
                        sd_buff_wr   <= 1'b1;
                        sd_buff_dout <= '0;
                        sd_buff_addr <= r_cnt;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end else if (r_cnt == AW'(1)) begin
                        // Two ERR cycles keep io_ack high for at least 3 clk.
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    io_ack  <= 1'b0;
                    r_gap   <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scsi_sector_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scsi_sector_mover
//  Description : Scoreboard bench for scsi_sector_mover. Stimulus pushes the
//                expected backend commands, buffer writes and media bytes
//                into queues; backend and buffer monitors pop and compare.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scsi_sector_mover;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic [31:0] img_blocks;
    logic [31:0] io_lba;
    logic        io_rd, io_wr, io_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic        blk_req, blk_write, blk_gnt;
    logic [31:0] blk_lba;
    logic [7:0]  rd_data, wr_data;
    logic        rd_valid, rd_ready, wr_valid, wr_ready;
    logic        range_err;

    scsi_sector_mover #(.SECTOR_BYTES(512), .LBA_W(32)) dut (
        .clk(clk), .reset(reset),
        .img_mounted(img_mounted), .img_blocks(img_blocks),
        .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr), .io_ack(io_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .blk_req(blk_req), .blk_write(blk_write), .blk_lba(blk_lba), .blk_gnt(blk_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    wire [63:0] all_outs = {io_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, blk_req, blk_write,
                            blk_lba, rd_ready, wr_data, wr_valid, range_err};

    int nvec = 0;
    int nfail = 0;

    // Reference state
    logic [7:0]  mem     [0:511];   // buffer contents the DUT reads for media writes
    logic [7:0]  pattern [0:511];   // byte stream the backend returns for reads
    logic [32:0] exp_cmd [$];       // {write, lba}
    logic [16:0] exp_buf [$];       // {addr, data}
    logic [7:0]  exp_wr  [$];
    logic [31:0] m_img_size;
    int          rd_mode;           // 0 always valid, 1 alternate, 2 random
    int          wr_pct;
    bit          rd_active;
    int          rd_idx;
    int          strobes, ack_rises, ack_falls, n_req;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        nvec++;
        if (act < lo || act > hi) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // ---------------- backend model ----------------
    initial begin
        bit rd_hs;
        int gnt_cnt;
        bit wv_prev, acc_prev, phase;
        logic [7:0] wd_prev;
        rd_hs = 0; gnt_cnt = -1; wv_prev = 0; acc_prev = 0; phase = 0; wd_prev = '0;
        blk_gnt = 0; rd_valid = 0; rd_data = '0; wr_ready = 0;
        rd_active = 0; rd_idx = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                blk_gnt = 0; rd_valid = 0; wr_ready = 0;
                rd_active = 0; rd_hs = 0; gnt_cnt = -1; wv_prev = 0; acc_prev = 0;
            end else begin
                if (rd_hs) rd_idx++;
                if (rd_active && rd_idx >= 512) rd_active = 0;
                blk_gnt = 0;
                if (blk_req) begin
                    if (gnt_cnt < 0) gnt_cnt = $urandom_range(0, 3);
                    if (gnt_cnt == 0) begin
                        blk_gnt = 1;
                        gnt_cnt = -1;
                        if (exp_cmd.size() == 0) begin
                            check("blk_cmd_unexpected", {blk_write, blk_lba}, 33'h0);
                            nfail += (blk_write === 1'b0 && blk_lba === 32'h0) ? 1 : 0;
                        end else begin
                            check("blk_cmd", {blk_write, blk_lba}, exp_cmd.pop_front());
                        end
                        if (!blk_write) begin
                            rd_active = 1;
                            rd_idx = 0;
                        end
                    end else begin
                        gnt_cnt--;
                    end
                end else if (io_ack && $urandom_range(0, 19) == 0) begin
                    blk_gnt = 1;   // stray grant, must be ignored
                end
                // read stream; junk is offered whenever no read is active
                phase = ~phase;
                if (rd_active) begin
                    rd_data  = pattern[rd_idx];
                    rd_valid = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? phase : 1'($urandom_range(0, 1));
                end else begin
                    rd_data  = 8'($urandom);
                    rd_valid = 1'($urandom_range(0, 1));
                end
                rd_hs = rd_valid && rd_ready;
                // write stream
                if (wv_prev && !acc_prev)
                    check("wr_hold", {wr_valid, wr_data}, {1'b1, wd_prev});
                wr_ready = ($urandom_range(1, 100) <= wr_pct);
                acc_prev = wr_valid && wr_ready;
                if (acc_prev) begin
                    if (exp_wr.size() == 0) begin
                        nvec++; nfail++;
                        $display("FAIL wr_unexpected: got byte %0h expected none", wr_data);
                    end else begin
                        check("wr_data", wr_data, exp_wr.pop_front());
                    end
                end
                wv_prev = wr_valid;
                wd_prev = wr_data;
            end
        end
    end

    // ---------------- buffer / io_ack monitor ----------------
    initial begin
        logic [8:0] addr_q;
        bit prev_ack;
        int ack_high;
        addr_q = '0; prev_ack = 0; ack_high = 0;
        sd_buff_din = '0; strobes = 0; ack_rises = 0; ack_falls = 0;
        forever begin
            @(negedge clk);
            // buffer RAM with one clock of read latency
            sd_buff_din = mem[addr_q];
            addr_q = sd_buff_addr;
            if (reset) begin
                prev_ack = 0;
                ack_high = 0;
            end else begin
                if (sd_buff_wr) begin
                    strobes++;
                    if (exp_buf.size() == 0) begin
                        nvec++; nfail++;
                        $display("FAIL buf_unexpected: got addr %0h data %0h expected none",
                                 sd_buff_addr, sd_buff_dout);
                    end else begin
                        check("buf_write", {sd_buff_addr, sd_buff_dout}, exp_buf.pop_front());
                    end
                end
                if (io_ack && !prev_ack) begin
                    ack_rises++;
                    ack_high = 0;
                end
                if (io_ack) ack_high++;
                if (!io_ack && prev_ack) begin
                    ack_falls++;
                    check_range("ack_high_time", ack_high, 3, 100000);
                end
                prev_ack = io_ack;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic mount(input logic [31:0] v);
        @(negedge clk);
        img_blocks  = v;
        img_mounted = 1;
        @(negedge clk);
        img_mounted = 0;
        m_img_size  = v;
    endtask

    task automatic wait_ack(input logic v, input int lim, input string nm);
        int n = 0;
        while (io_ack !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (io_ack !== v) check(nm, io_ack, v);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] lba, input logic [31:0] mid_blocks);
        bit oor;
        int s0;
        int low;
        oor = (lba >= m_img_size);
        if (rd) begin
            if (!oor) exp_cmd.push_back({1'b0, lba});
            for (int k = 0; k < 512; k++)
                exp_buf.push_back({9'(k), oor ? 8'h00 : pattern[k]});
        end
        if (wr && !oor) begin
            exp_cmd.push_back({1'b1, lba});
            for (int k = 0; k < 512; k++) exp_wr.push_back(mem[k]);
        end
        s0 = strobes;
        n_req += (rd && wr) ? 2 : 1;
        @(negedge clk);
        io_lba = lba; io_rd = rd; io_wr = wr;
        wait_ack(1'b1, 20, "ack_rise_timeout");
        io_rd = 0;
        if (!rd) io_wr = 0;
        if (mid_blocks != 0) begin
            repeat (10) @(negedge clk);
            mount(mid_blocks);
        end
        wait_ack(1'b0, 6000, "ack_fall_timeout");
        if (rd && wr) begin
            low = 1;
            while (low < 20) begin
                @(negedge clk);
                if (io_ack) break;
                low++;
            end
            check_range("rw_gap_low_cycles", low, 2, 3);
            io_wr = 0;
            wait_ack(1'b0, 6000, "ack_fall_timeout");
        end
        check("range_err", range_err, oor);
        check("buf_strobes", strobes - s0, rd ? 512 : 0);
        check("cmd_q_left", exp_cmd.size(), 0);
        check("buf_q_left", exp_buf.size(), 0);
        check("wr_q_left", exp_wr.size(), 0);
    endtask

    initial begin
        reset = 1; img_mounted = 0; img_blocks = '0; io_lba = '0; io_rd = 0; io_wr = 0;
        m_img_size = '0; rd_mode = 0; wr_pct = 50; n_req = 0;
        for (int k = 0; k < 512; k++) begin mem[k] = '0; pattern[k] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, 64'h0);
        reset = 0;
        @(negedge clk);
        mount(100);

        for (int k = 0; k < 512; k++) pattern[k] = 8'(k);
        rd_mode = 0; issue(1, 0, 5, 0);
        rd_mode = 1; issue(1, 0, 5, 0);

        for (int k = 0; k < 512; k++) mem[k] = 8'hA5 ^ 8'(k);
        wr_pct = 30; issue(0, 1, 7, 8);       // image shrinks to 8 sectors mid-write
        rd_mode = 2; issue(1, 0, 9, 0);       // 9 >= 8: zero fill

        mount(100);
        issue(1, 0, 100, 0);
        for (int k = 0; k < 512; k++) pattern[k] = 8'($urandom);
        issue(1, 0, 99, 0);
        issue(0, 1, 150, 0);

        for (int k = 0; k < 512; k++) begin pattern[k] = 8'($urandom); mem[k] = 8'($urandom); end
        rd_mode = 0; wr_pct = 60;
        issue(1, 1, 10, 0);

        for (int it = 0; it < 4; it++) begin
            bit d;
            d = 1'($urandom_range(0, 1));
            for (int k = 0; k < 512; k++) begin pattern[k] = 8'($urandom); mem[k] = 8'($urandom); end
            rd_mode = $urandom_range(0, 2);
            wr_pct  = $urandom_range(20, 100);
            issue(d, ~d, $urandom_range(0, 130), 0);
        end

        // asynchronous reset in the middle of a read
        for (int k = 0; k < 512; k++) pattern[k] = 8'($urandom);
        rd_mode = 0;
        exp_cmd.push_back({1'b0, 32'd40});
        for (int k = 0; k < 512; k++) exp_buf.push_back({9'(k), pattern[k]});
        n_req++;
        @(negedge clk);
        io_lba = 40; io_rd = 1;
        wait_ack(1'b1, 20, "ack_rise_timeout");
        io_rd = 0;
        begin
            int n = 0;
            while (rd_idx < 200 && n < 2000) begin @(negedge clk); n++; end
            if (rd_idx < 200) check("beat200_timeout", rd_idx, 200);
        end
        #2 reset = 1;
        #1 check("async_reset_outputs", all_outs, 64'h0);
        exp_cmd.delete(); exp_buf.delete(); exp_wr.delete();
        m_img_size = '0;
        repeat (2) @(negedge clk);
        reset = 0;
        mount(100);
        for (int k = 0; k < 512; k++) pattern[k] = 8'($urandom);
        issue(1, 0, 3, 0);

        check("ack_rises", ack_rises, n_req);
        check("ack_falls", ack_falls, n_req - 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
